// File: rtl/a51_phase_sequencer_if.sv
// Control/status bundle between the A5/1 run controller and its sequencer.
// The controller drives START/ENABLE/ABORT; the sequencer reports phase and progress.
interface a51_phase_sequencer_if #(
    parameter int CNT_W = 10
);
    logic             START;
    logic             ENABLE;
    logic             ABORT;
    logic [CNT_W-1:0] Q;
    logic [CNT_W-1:0] TOTAL;
    logic             STAGEONE;
    logic             STAGETWO;
    logic             STAGETHREE;
    logic             OUTPUTSTAGE;
    logic             DONE;
    logic             BUSY;
    logic             LAST;

    modport master (
        output START, ENABLE, ABORT,
        input  Q, TOTAL, STAGEONE, STAGETWO, STAGETHREE,
        input  OUTPUTSTAGE, DONE, BUSY, LAST
    );

    modport slave (
        input  START, ENABLE, ABORT,
        output Q, TOTAL, STAGEONE, STAGETWO, STAGETHREE,
        output OUTPUTSTAGE, DONE, BUSY, LAST
    );
endinterface

// File: rtl/a51_phase_sequencer.sv
// A5/1 run sequencer: KEY -> FRAME -> MIX -> OUT -> FIN with per-phase bit index.
// Phase lengths are parameters; all outputs decode from registers only.
module a51_phase_sequencer #(
    parameter int KEY_LEN   = 64,
    parameter int FRAME_LEN = 22,
    parameter int MIX_LEN   = 100,
    parameter int OUT_LEN   = 128,
    parameter int CNT_W     = 10
) (
    input  logic C,
    input  logic CLR,
    a51_phase_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_FRAME,
        S_MIX,
        S_OUT,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] q_q, q_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic [CNT_W-1:0] len_m1;
    logic             busy;
    logic             at_end;

    always_ff @(posedge C or negedge CLR) begin
        if (!CLR) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            tot_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tot_q   <= tot_d;
        end
    end

    always_comb begin
        len_m1 = '0;
        unique case (state_q)
            S_KEY:   len_m1 = CNT_W'(KEY_LEN - 1);
            S_FRAME: len_m1 = CNT_W'(FRAME_LEN - 1);
            S_MIX:   len_m1 = CNT_W'(MIX_LEN - 1);
            S_OUT:   len_m1 = CNT_W'(OUT_LEN - 1);
            default: len_m1 = '0;
        endcase
    end

    assign busy   = (state_q == S_KEY) || (state_q == S_FRAME) ||
                    (state_q == S_MIX) || (state_q == S_OUT);
    assign at_end = busy && (q_q == len_m1);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tot_d   = tot_q;
        if (bus.ABORT) begin
            state_d = S_IDLE;
            q_d     = '0;
            tot_d   = '0;
        end else if (bus.START && !busy) begin
            // START only launches from IDLE or FIN; mid-run it is ignored
            state_d = S_KEY;
            q_d     = '0;
            tot_d   = '0;
        end else if (busy && bus.ENABLE) begin
            tot_d = tot_q + 1'b1;
            if (at_end) begin
                q_d = '0;
                unique case (state_q)
                    S_KEY:   state_d = S_FRAME;
                    S_FRAME: state_d = S_MIX;
                    S_MIX:   state_d = S_OUT;
                    S_OUT:   state_d = S_FIN;
                    default: state_d = S_IDLE;
                endcase
            end else begin
                q_d = q_q + 1'b1;
            end
        end
    end

    assign bus.Q           = q_q;
    assign bus.TOTAL       = tot_q;
    assign bus.STAGEONE    = (state_q == S_KEY);
    assign bus.STAGETWO    = (state_q == S_FRAME);
    assign bus.STAGETHREE  = (state_q == S_MIX);
    assign bus.OUTPUTSTAGE = (state_q == S_OUT);
    assign bus.DONE        = (state_q == S_FIN);
    assign bus.BUSY        = busy;
    assign bus.LAST        = at_end;
endmodule

// File: tb/tb_a51_phase_sequencer.sv
// Bench for a51_phase_sequencer: progress-count model plus directed phase checks.
// Two instances: default lengths and a tiny 1/1/2/3 configuration.
module tb_a51_phase_sequencer;
    localparam int SUM1 = 64 + 22 + 100 + 128;
    localparam int SUM2 = 1 + 1 + 2 + 3;

    typedef struct packed {
        logic [9:0] q;
        logic [9:0] total;
        logic       s1;
        logic       s2;
        logic       s3;
        logic       so;
        logic       done;
        logic       busy;
        logic       last;
    } obs_t;

    logic C = 1'b0;
    logic CLR = 1'b0;
    int   passed = 0;
    int   total_checks = 0;

    always #5 C = ~C;

    a51_phase_sequencer_if #(.CNT_W(10)) b1 ();
    a51_phase_sequencer_if #(.CNT_W(10)) b2 ();

    a51_phase_sequencer dut1 (
        .C(C), .CLR(CLR), .bus(b1.slave)
    );

    a51_phase_sequencer #(
        .KEY_LEN(1), .FRAME_LEN(1), .MIX_LEN(2), .OUT_LEN(3), .CNT_W(10)
    ) dut2 (
        .C(C), .CLR(CLR), .bus(b2.slave)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total_checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected outputs from "running?" and "cycles advanced since START"
    function automatic obs_t model_out(bit act, int t, int k, int f, int m, int o);
        obs_t r;
        r = '0;
        if (act) begin
            r.total = 10'(t);
            r.busy  = 1'b1;
            if (t < k) begin
                r.s1 = 1'b1; r.q = 10'(t); r.last = (t == k - 1);
            end else if (t < k + f) begin
                r.s2 = 1'b1; r.q = 10'(t - k); r.last = (t == k + f - 1);
            end else if (t < k + f + m) begin
                r.s3 = 1'b1; r.q = 10'(t - k - f);
                r.last = (t == k + f + m - 1);
            end else if (t < k + f + m + o) begin
                r.so = 1'b1; r.q = 10'(t - k - f - m);
                r.last = (t == k + f + m + o - 1);
            end else begin
                r.busy = 1'b0; r.done = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic obs_t obs1();
        return {b1.Q, b1.TOTAL, b1.STAGEONE, b1.STAGETWO, b1.STAGETHREE,
                b1.OUTPUTSTAGE, b1.DONE, b1.BUSY, b1.LAST};
    endfunction

    function automatic obs_t obs2();
        return {b2.Q, b2.TOTAL, b2.STAGEONE, b2.STAGETWO, b2.STAGETHREE,
                b2.OUTPUTSTAGE, b2.DONE, b2.BUSY, b2.LAST};
    endfunction

    bit a1, a2;
    int t1, t2;

    always @(posedge C or negedge CLR) begin
        if (!CLR) begin
            a1 <= 1'b0; t1 <= 0;
        end else if (b1.ABORT) begin
            a1 <= 1'b0; t1 <= 0;
        end else if (b1.START && (!a1 || t1 == SUM1)) begin
            a1 <= 1'b1; t1 <= 0;
        end else if (a1 && t1 < SUM1 && b1.ENABLE) begin
            t1 <= t1 + 1;
        end
    end

    always @(posedge C or negedge CLR) begin
        if (!CLR) begin
            a2 <= 1'b0; t2 <= 0;
        end else if (b2.ABORT) begin
            a2 <= 1'b0; t2 <= 0;
        end else if (b2.START && (!a2 || t2 == SUM2)) begin
            a2 <= 1'b1; t2 <= 0;
        end else if (a2 && t2 < SUM2 && b2.ENABLE) begin
            t2 <= t2 + 1;
        end
    end

    always @(negedge C) begin
        chk("dut1 outputs", 32'(obs1()), 32'(model_out(a1, t1, 64, 22, 100, 128)));
        chk("dut2 outputs", 32'(obs2()), 32'(model_out(a2, t2, 1, 1, 2, 3)));
    end

    task automatic tick(int n);
        repeat (n) @(posedge C);
        #1;
    endtask

    int lastcnt;
    int phase_seq [7];
    int exp_seq [7] = '{1, 2, 3, 3, 4, 4, 4};

    initial begin
        b1.START = 0; b1.ENABLE = 0; b1.ABORT = 0;
        b2.START = 0; b2.ENABLE = 0; b2.ABORT = 0;
        #12;
        chk("reset busy", 32'(b1.BUSY), 0);
        chk("reset total", 32'(b1.TOTAL), 0);
        @(negedge C); #1 CLR = 1;

        // Reset mid-run in FRAME phase
        b1.START = 1; b1.ENABLE = 1;
        tick(1);
        b1.START = 0;
        tick(69);
        chk("t1 stagetwo", 32'(b1.STAGETWO), 1);
        chk("t1 q", 32'(b1.Q), 5);
        #2 CLR = 0;
        #1;
        chk("t1 clr q", 32'(b1.Q), 0);
        chk("t1 clr total", 32'(b1.TOTAL), 0);
        chk("t1 clr stagetwo", 32'(b1.STAGETWO), 0);
        chk("t1 clr busy", 32'(b1.BUSY), 0);
        @(negedge C); #1 CLR = 1;

        // Full run with defaults
        b1.START = 1; b1.ENABLE = 1;
        tick(1);
        b1.START = 0;
        lastcnt = 0;
        repeat (SUM1) begin
            if (b1.LAST) lastcnt++;
            tick(1);
        end
        chk("t2 last count", 32'(lastcnt), 4);
        chk("t2 done", 32'(b1.DONE), 1);
        chk("t2 total", 32'(b1.TOTAL), 314);
        chk("t2 q", 32'(b1.Q), 0);

        // DONE hold, then restart
        b1.ENABLE = 0;
        tick(10);
        chk("t5 done held", 32'(b1.DONE), 1);
        b1.START = 1;
        tick(1);
        b1.START = 0;
        chk("t5 stageone", 32'(b1.STAGEONE), 1);
        chk("t5 q", 32'(b1.Q), 0);
        chk("t5 total", 32'(b1.TOTAL), 0);
        chk("t5 done", 32'(b1.DONE), 0);

        // Stall on the KEY boundary
        b1.ENABLE = 1;
        tick(63);
        b1.ENABLE = 0;
        tick(5);
        chk("t3 q held", 32'(b1.Q), 63);
        chk("t3 last held", 32'(b1.LAST), 1);
        chk("t3 stageone", 32'(b1.STAGEONE), 1);
        b1.ENABLE = 1;
        tick(1);
        chk("t3 stagetwo", 32'(b1.STAGETWO), 1);
        chk("t3 q", 32'(b1.Q), 0);

        // START mid-MIX ignored, ABORT wins over START
        tick(62);
        chk("t4 mix q", 32'(b1.Q), 40);
        b1.START = 1;
        tick(1);
        b1.START = 0;
        chk("t4 no restart q", 32'(b1.Q), 41);
        chk("t4 no restart total", 32'(b1.TOTAL), 127);
        tick(9);
        chk("t4 q50", 32'(b1.Q), 50);
        b1.ABORT = 1; b1.START = 1;
        tick(1);
        b1.ABORT = 0; b1.START = 0;
        chk("t4 abort busy", 32'(b1.BUSY), 0);
        chk("t4 abort q", 32'(b1.Q), 0);
        chk("t4 abort total", 32'(b1.TOTAL), 0);
        chk("t4 abort mix", 32'(b1.STAGETHREE), 0);

        // Short phases: 1/1/2/3
        b2.START = 1; b2.ENABLE = 1;
        tick(1);
        b2.START = 0;
        for (int i = 0; i < 7; i++) begin
            phase_seq[i] = b2.STAGEONE ? 1 : b2.STAGETWO ? 2 :
                           b2.STAGETHREE ? 3 : b2.OUTPUTSTAGE ? 4 : 0;
            chk("t6 phase", 32'(phase_seq[i]), 32'(exp_seq[i]));
            if (i == 0) chk("t6 last len1", 32'(b2.LAST), 1);
            if (i < 6) tick(1);
        end
        chk("t6 last end", 32'(b2.LAST), 1);
        chk("t6 not done", 32'(b2.DONE), 0);
        tick(1);
        chk("t6 done", 32'(b2.DONE), 1);
        chk("t6 total", 32'(b2.TOTAL), 7);
        b2.ENABLE = 0;
        tick(2);

        $display("%0d/%0d checks passed", passed, total_checks);
        $finish;
    end
endmodule
